// File: rtl/pacemaker_sense_frontend.sv
// Three-chamber electrogram sense front end. Each channel runs ARMED -> CONFIRM -> REFRACT -> REARM,
// with BLANK forced by pacing pulses. All outputs are registered.
module pacemaker_sense_frontend #(
  parameter int SAMPLE_W        = 8,
  parameter int TH_SHIFT        = 2,
  parameter int CONFIRM_N       = 3,
  parameter int REFRACT_SAMPLES = 50,
  parameter int BLANK_SAMPLES   = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] samp_a,
  input  logic signed [SAMPLE_W-1:0] samp_v,
  input  logic signed [SAMPLE_W-1:0] samp_lv,
  input  logic                       sense_pol_a,
  input  logic                       sense_pol_v,
  input  logic                       sense_pol_lv,
  input  logic [4:0]                 sense_a_th,
  input  logic [4:0]                 sense_v_th,
  input  logic [4:0]                 sense_lv_th,
  input  logic [4:0]                 sense_er_th,
  input  logic                       pace_a,
  input  logic                       pace_rv,
  input  logic                       pace_lv,
  output logic                       sense_a,
  output logic                       sense_v,
  output logic                       sense_lv,
  output logic [2:0]                 sense_event
);

  localparam int MAG_W = SAMPLE_W - 1;
  localparam int THR_W = 5 + TH_SHIFT;
  localparam int CMP_W = (MAG_W > THR_W) ? MAG_W : THR_W;
  localparam int SPAN  = (REFRACT_SAMPLES > BLANK_SAMPLES) ? REFRACT_SAMPLES : BLANK_SAMPLES;
  localparam int TMR_W = $clog2(SPAN + 1);
  localparam int CNF_W = $clog2(CONFIRM_N + 1);

  localparam logic [CNF_W-1:0] CNF_LAST     = CNF_W'(CONFIRM_N - 1);
  localparam logic [TMR_W-1:0] REFRACT_LAST = TMR_W'(REFRACT_SAMPLES - 1);
  localparam logic [TMR_W-1:0] BLANK_LAST   = TMR_W'(BLANK_SAMPLES - 1);
  localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {MAG_W{1'b0}}};

  typedef enum logic [2:0] {ARMED, CONFIRM, REFRACT, REARM, BLANK} state_t;

  function automatic logic [MAG_W-1:0] magnitude(input logic signed [SAMPLE_W-1:0] s,
                                                 input logic pol);
    logic [SAMPLE_W-1:0] neg;
    logic [MAG_W-1:0]    m;
    neg = -s;
    m   = '0;
    if (!pol) begin
      if (s > 0) m = s[MAG_W-1:0];
    end else if (s < 0) begin
      // The most negative sample has no positive twin; clamp it to full scale.
      m = (s == S_MIN) ? '1 : neg[MAG_W-1:0];
    end
    return m;
  endfunction

  function automatic logic at_least(input logic [MAG_W-1:0] mag, input logic [4:0] th);
    return CMP_W'(mag) >= (CMP_W'(th) << TH_SHIFT);
  endfunction

  logic signed [SAMPLE_W-1:0] samp [3];
  logic [4:0]                 th   [3];
  logic [MAG_W-1:0]           mag  [3];
  logic [2:0]                 pol, blank, hit, quiet;

  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch can be inferred.
    samp = '{samp_a, samp_v, samp_lv};
    th   = '{sense_a_th, sense_v_th, sense_lv_th};
    pol  = {sense_pol_lv, sense_pol_v, sense_pol_a};
    blank = {pace_rv | pace_lv, pace_rv | pace_lv, pace_a};
    hit   = '0;
    quiet = '0;
    for (int i = 0; i < 3; i++) begin
      mag[i]   = magnitude(samp[i], pol[i]);
      hit[i]   = (th[i] != '0) && at_least(mag[i], th[i]);
      quiet[i] = !at_least(mag[i], sense_er_th);
    end
  end

  state_t           state [3];
  logic [CNF_W-1:0] cnf   [3];
  logic [TMR_W-1:0] tmr   [3];
  logic [2:0]       sense_q, event_q;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every channel sees pre-edge values.
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state[i] <= ARMED;
        cnf[i]   <= '0;
        tmr[i]   <= '0;
      end
      sense_q <= '0;
      event_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        event_q[i] <= 1'b0;
        // Pacing outranks any strobe in the same cycle, including a confirming one.
        if (blank[i]) begin
          state[i]   <= BLANK;
          cnf[i]     <= '0;
          tmr[i]     <= '0;
          sense_q[i] <= 1'b0;
        end else if (sample_valid) begin
          case (state[i])
            ARMED: begin
              if (hit[i]) begin
                if (CONFIRM_N == 1) begin
                  state[i]   <= REFRACT;
                  tmr[i]     <= '0;
                  sense_q[i] <= 1'b1;
                  event_q[i] <= 1'b1;
                end else begin
                  state[i] <= CONFIRM;
                  cnf[i]   <= CNF_W'(1);
                end
              end
            end
            CONFIRM: begin
              if (!hit[i]) begin
                state[i] <= ARMED;
                cnf[i]   <= '0;
              end else if (cnf[i] == CNF_LAST) begin
                state[i]   <= REFRACT;
                cnf[i]     <= '0;
                tmr[i]     <= '0;
                sense_q[i] <= 1'b1;
                event_q[i] <= 1'b1;
              end else begin
                cnf[i] <= cnf[i] + 1'b1;
              end
            end
            REFRACT: begin
              if (tmr[i] == REFRACT_LAST) begin
                state[i]   <= REARM;
                tmr[i]     <= '0;
                sense_q[i] <= 1'b0;
              end else begin
                tmr[i] <= tmr[i] + 1'b1;
              end
            end
            BLANK: begin
              if (tmr[i] == BLANK_LAST) begin
                state[i] <= REARM;
                tmr[i]   <= '0;
              end else begin
                tmr[i] <= tmr[i] + 1'b1;
              end
            end
            REARM: begin
              if (quiet[i]) state[i] <= ARMED;
            end
            default: state[i] <= ARMED;
          endcase
        end
      end
    end
  end

  assign sense_a     = sense_q[0];
  assign sense_v     = sense_q[1];
  assign sense_lv    = sense_q[2];
  assign sense_event = event_q;

endmodule

// File: tb/tb_pacemaker_sense_frontend.sv
// Directed plus randomized bench for pacemaker_sense_frontend, checked every cycle against
// a countdown-based reference model of the sensing rules.
module tb_pacemaker_sense_frontend;

  localparam int CONFIRM_N = 3;
  localparam int REFRACT   = 50;
  localparam int BLANKN    = 10;
  localparam int MAG_MAX   = 127;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, sample_valid;
  logic signed [7:0] samp_a, samp_v, samp_lv;
  logic             sense_pol_a, sense_pol_v, sense_pol_lv;
  logic [4:0]       sense_a_th, sense_v_th, sense_lv_th, sense_er_th;
  logic             pace_a, pace_rv, pace_lv;
  logic             sense_a, sense_v, sense_lv;
  logic [2:0]       sense_event;

  pacemaker_sense_frontend dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .samp_a(samp_a), .samp_v(samp_v), .samp_lv(samp_lv),
    .sense_pol_a(sense_pol_a), .sense_pol_v(sense_pol_v), .sense_pol_lv(sense_pol_lv),
    .sense_a_th(sense_a_th), .sense_v_th(sense_v_th), .sense_lv_th(sense_lv_th),
    .sense_er_th(sense_er_th),
    .pace_a(pace_a), .pace_rv(pace_rv), .pace_lv(pace_lv),
    .sense_a(sense_a), .sense_v(sense_v), .sense_lv(sense_lv),
    .sense_event(sense_event)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: qualifying-run length, remaining refractory/blanking strobes, re-arm wait.
  int         run [3];
  int         refr_left [3];
  int         blank_left [3];
  bit         rearm_wait [3];
  logic [2:0] exp_ev;
  logic [2:0] ev_acc;

  function automatic int mag_of(input int s, input bit pol);
    int m;
    m = pol ? -s : s;
    if (m < 0) m = 0;
    if (m > MAG_MAX) m = MAG_MAX;
    return m;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      run[c] = 0; refr_left[c] = 0; blank_left[c] = 0; rearm_wait[c] = 0;
    end
    exp_ev = '0;
  endtask

  task automatic model_step(input bit stb, input bit [2:0] pace);
    int s [3];
    bit p [3];
    int t [3];
    int m;
    s = '{int'(samp_a), int'(samp_v), int'(samp_lv)};
    p = '{sense_pol_a, sense_pol_v, sense_pol_lv};
    t = '{int'(sense_a_th), int'(sense_v_th), int'(sense_lv_th)};
    exp_ev = '0;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 3; c++) begin
      if (pace[c]) begin
        blank_left[c] = BLANKN; run[c] = 0; refr_left[c] = 0; rearm_wait[c] = 0;
        continue;
      end
      if (!stb) continue;
      m = mag_of(s[c], p[c]);
      if (blank_left[c] > 0) begin
        blank_left[c]--;
        if (blank_left[c] == 0) rearm_wait[c] = 1;
      end else if (refr_left[c] > 0) begin
        refr_left[c]--;
        if (refr_left[c] == 0) rearm_wait[c] = 1;
      end else if (rearm_wait[c]) begin
        if (m < int'(sense_er_th) * 4) rearm_wait[c] = 0;
      end else if (t[c] == 0 || m < t[c] * 4) begin
        run[c] = 0;
      end else begin
        run[c]++;
        if (run[c] == CONFIRM_N) begin
          exp_ev[c] = 1'b1; run[c] = 0; refr_left[c] = REFRACT;
        end
      end
    end
  endtask

  function automatic logic [2:0] exp_sense();
    return {refr_left[2] > 0, refr_left[1] > 0, refr_left[0] > 0};
  endfunction

  // One clock: apply inputs, advance the model at the edge, check all outputs 1 ns later.
  task automatic cyc(input bit stb, input bit pa, input bit prv, input bit plv);
    sample_valid = stb; pace_a = pa; pace_rv = prv; pace_lv = plv;
    @(posedge clk);
    model_step(stb, {prv | plv, prv | plv, pa});
    #1;
    check("sense", {sense_lv, sense_v, sense_a}, exp_sense());
    check("event", sense_event, exp_ev);
    ev_acc |= sense_event;
    sample_valid = 0; pace_a = 0; pace_rv = 0; pace_lv = 0;
  endtask

  task automatic strobes(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
    end
  endtask

  initial begin
    int hi;
    logic signed [7:0] seq [5];
    rst = 1; sample_valid = 0; pace_a = 0; pace_rv = 0; pace_lv = 0;
    samp_a = 100; samp_v = 100; samp_lv = 100;
    sense_pol_a = 0; sense_pol_v = 1; sense_pol_lv = 0;
    sense_a_th = 8; sense_v_th = 31; sense_lv_th = 0; sense_er_th = 5;
    model_reset();

    // Reset held with large samples, then first detection on the 3rd strobe.
    repeat (3) cyc(1, 0, 0, 0);
    check("reset_out", {sense_event, sense_lv, sense_v, sense_a}, 6'd0);
    rst = 0;
    cyc(1, 0, 0, 0); check("pre_evt1", sense_event, 3'b000);
    cyc(1, 0, 0, 0); check("pre_evt2", sense_event, 3'b000);
    cyc(1, 0, 0, 0); check("evt_3rd", sense_event, 3'b001);
    samp_a = 10;
    strobes(55);

    // A: 40,40,40 -> event, then refractory spans exactly 50 strobes.
    samp_a = 40;
    strobes(2);
    cyc(1, 0, 0, 0); check("a40_evt", sense_event, 3'b001);
    hi = 0;
    for (int k = 0; k < 55; k++) begin
      repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0);
      samp_a = 8'($urandom_range(0, 19));
      if (sense_a) hi++;
      cyc(1, 0, 0, 0);
    end
    check("a_refract_len", hi, 50);

    // A: 40,40,10,40,40 -> confirmation restarts, no event.
    seq = '{8'sd40, 8'sd40, 8'sd10, 8'sd40, 8'sd40};
    ev_acc = '0;
    for (int k = 0; k < 5; k++) begin
      samp_a = seq[k];
      cyc(1, 0, 0, 0);
    end
    check("a_restart_no_evt", ev_acc[0], 1'b0);
    samp_a = 10;
    strobes(1);

    // V: negative polarity, -128 saturates to 127 >= 124; +127 gives nothing.
    samp_v = -128;
    strobes(2);
    cyc(1, 0, 0, 0); check("v_sat_evt", sense_event, 3'b010);
    samp_v = 0;
    strobes(52);
    samp_v = 127; ev_acc = '0;
    strobes(5);
    check("v_pos_no_evt", ev_acc[1], 1'b0);

    // V at cnt=2, pace_rv with the confirming strobe; blanking restarted by pace_lv.
    sense_lv_th = 8; samp_lv = 0; samp_v = -128;
    strobes(2);
    cyc(1, 0, 1, 0); check("pace_wins", sense_event, 3'b000);
    samp_lv = 100; samp_a = 40; ev_acc = '0;
    strobes(4);
    cyc(0, 0, 0, 1);
    strobes(10);
    check("vlv_blanked", ev_acc[2:1], 2'b00);
    check("a_unaffected", ev_acc[0], 1'b1);
    samp_v = 0; samp_lv = 0;
    strobes(1);

    // A after refraction: held at 40 stays in re-arm; a quiet sample re-arms it.
    ev_acc = '0;
    strobes(60);
    check("a_no_redetect", ev_acc[0], 1'b0);
    samp_a = 10;
    strobes(1);
    samp_a = 40;
    strobes(2);
    cyc(1, 0, 0, 0); check("a_redetect", sense_event, 3'b001);

    // Randomized soak with occasional pacing, settings changes and a mid-run reset.
    for (int k = 0; k < 600; k++) begin
      samp_a = 8'($urandom); samp_v = 8'($urandom); samp_lv = 8'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        sense_pol_a = 1'($urandom); sense_pol_v = 1'($urandom); sense_pol_lv = 1'($urandom);
        sense_a_th = 5'($urandom); sense_v_th = 5'($urandom);
        sense_lv_th = 5'($urandom); sense_er_th = 5'($urandom_range(1, 31));
      end
      rst = (k == 300 || k == 301);
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0);
      if (k == 301) check("midrun_reset", {sense_event, sense_lv, sense_v, sense_a}, 6'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
